// File: rtl/player_step_ctrl.sv
// Tile-stepping player controller: one step per tick_in edge, gated by a collision query.
// Position lands two edges after the step at best; steps arriving mid-query are dropped.
module player_step_ctrl #(
  parameter int GRID_W      = 20,
  parameter int GRID_H      = 15,
  parameter int X_W         = 5,
  parameter int Y_W         = 4,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  parameter int QRY_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_in,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  output logic           qry_valid,
  output logic [X_W-1:0] qry_x,
  output logic [Y_W-1:0] qry_y,
  input  logic           qry_ack,
  input  logic           qry_blocked,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     facing,
  output logic [1:0]     anim_frame,
  output logic           moving,
  output logic           step_done
);

  localparam int CNT_W = (QRY_TIMEOUT > 1) ? $clog2(QRY_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_QUERY, S_MOVE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_tick_q;
  logic [X_W-1:0]   r_pos_x, w_pos_x_nxt;
  logic [Y_W-1:0]   r_pos_y, w_pos_y_nxt;
  logic [1:0]       r_facing, w_facing_nxt;
  logic [1:0]       r_anim, w_anim_nxt;
  logic             r_moving, w_moving_nxt;
  logic             r_qry_valid, w_qry_valid_nxt;
  logic [X_W-1:0]   r_qry_x, w_qry_x_nxt;
  logic [Y_W-1:0]   r_qry_y, w_qry_y_nxt;
  logic             r_step_done, w_step_done_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_step;
  logic             w_btn;
  logic [1:0]       w_dir;
  logic [X_W-1:0]   w_tgt_x;
  logic [Y_W-1:0]   w_tgt_y;
  logic             w_off_grid;
  logic             w_timeout;
  logic             w_qry_end;
  logic             w_qry_pass;

  // Both edges of the divider square wave count as a step.
  assign w_step     = tick_in ^ r_tick_q;
  assign w_btn      = btn_up | btn_down | btn_left | btn_right;
  assign w_timeout  = (r_cnt == CNT_W'(QRY_TIMEOUT - 1));
  assign w_qry_end  = qry_ack | w_timeout;
  assign w_qry_pass = qry_ack & ~qry_blocked;

  always_comb begin
    w_dir      = 2'b11;
    w_tgt_x    = r_pos_x;
    w_tgt_y    = r_pos_y;
    w_off_grid = 1'b0;
    if (btn_up)         w_dir = 2'b00;
    else if (btn_down)  w_dir = 2'b01;
    else if (btn_left)  w_dir = 2'b10;
    case (w_dir)
      2'b00: begin
        w_off_grid = (r_pos_y == '0);
        w_tgt_y    = r_pos_y - Y_W'(1);
      end
      2'b01: begin
        w_off_grid = (r_pos_y == Y_W'(GRID_H - 1));
        w_tgt_y    = r_pos_y + Y_W'(1);
      end
      2'b10: begin
        w_off_grid = (r_pos_x == '0);
        w_tgt_x    = r_pos_x - X_W'(1);
      end
      default: begin
        w_off_grid = (r_pos_x == X_W'(GRID_W - 1));
        w_tgt_x    = r_pos_x + X_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_step && w_btn && !w_off_grid) w_state_nxt = S_QUERY;
      S_QUERY: begin
        if (w_qry_pass)     w_state_nxt = S_MOVE;
        else if (w_qry_end) w_state_nxt = S_IDLE;
      end
      S_MOVE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pos_x_nxt     = r_pos_x;
    w_pos_y_nxt     = r_pos_y;
    w_facing_nxt    = r_facing;
    w_anim_nxt      = r_anim;
    w_moving_nxt    = r_moving;
    w_qry_valid_nxt = r_qry_valid;
    w_qry_x_nxt     = r_qry_x;
    w_qry_y_nxt     = r_qry_y;
    w_step_done_nxt = 1'b0;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_step) begin
          if (!w_btn) begin
            w_moving_nxt = 1'b0;
            w_anim_nxt   = 2'd0;
          end else begin
            w_facing_nxt = w_dir;
            if (w_off_grid) begin
              w_moving_nxt = 1'b0;
              w_anim_nxt   = 2'd0;
            end else begin
              w_qry_x_nxt     = w_tgt_x;
              w_qry_y_nxt     = w_tgt_y;
              w_qry_valid_nxt = 1'b1;
              w_cnt_nxt       = '0;
            end
          end
        end
      end
      S_QUERY: begin
        // A timeout is folded into the blocked path.
        if (w_qry_end) begin
          w_qry_valid_nxt = 1'b0;
          if (!w_qry_pass) begin
            w_moving_nxt = 1'b0;
            w_anim_nxt   = 2'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_MOVE: begin
        w_pos_x_nxt     = r_qry_x;
        w_pos_y_nxt     = r_qry_y;
        w_anim_nxt      = r_anim + 2'd1;
        w_moving_nxt    = 1'b1;
        w_step_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_q    <= 1'b0;
      r_pos_x     <= X_W'(START_X);
      r_pos_y     <= Y_W'(START_Y);
      r_facing    <= 2'b01;
      r_anim      <= 2'd0;
      r_moving    <= 1'b0;
      r_qry_valid <= 1'b0;
      r_qry_x     <= '0;
      r_qry_y     <= '0;
      r_step_done <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_tick_q    <= tick_in;
      r_pos_x     <= w_pos_x_nxt;
      r_pos_y     <= w_pos_y_nxt;
      r_facing    <= w_facing_nxt;
      r_anim      <= w_anim_nxt;
      r_moving    <= w_moving_nxt;
      r_qry_valid <= w_qry_valid_nxt;
      r_qry_x     <= w_qry_x_nxt;
      r_qry_y     <= w_qry_y_nxt;
      r_step_done <= w_step_done_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign facing     = r_facing;
  assign anim_frame = r_anim;
  assign moving     = r_moving;
  assign qry_valid  = r_qry_valid;
  assign qry_x      = r_qry_x;
  assign qry_y      = r_qry_y;
  assign step_done  = r_step_done;

endmodule

// File: tb/tb_player_step_ctrl.sv
// Directed vector bench for player_step_ctrl: a step table plus hand sequences
// for ack-while-idle, query timeout with a dropped step, and reset mid-query.
module tb_player_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       qry_valid;
  logic [4:0] qry_x;
  logic [3:0] qry_y;
  logic       qry_ack, qry_blocked;
  logic [4:0] pos_x;
  logic [3:0] pos_y;
  logic [1:0] facing, anim_frame;
  logic       moving, step_done;

  int n_cmp = 0;
  int n_bad = 0;

  player_step_ctrl dut (
    .clk(clk), .rst(rst), .tick_in(tick_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .qry_valid(qry_valid), .qry_x(qry_x), .qry_y(qry_y),
    .qry_ack(qry_ack), .qry_blocked(qry_blocked),
    .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .anim_frame(anim_frame),
    .moving(moving), .step_done(step_done)
  );

  always #5 clk = ~clk;

  // btn is {up, down, left, right}; k is the ack delay in edges after the step edge.
  typedef struct {
    logic [3:0] btn;
    int         k;
    bit         blk;
    bit         qry;
    int         tx, ty;
    int         ex, ey;
    logic [1:0] fac;
    int         anim;
    bit         mov;
  } vec_t;

  vec_t vecs[35];
  int   cur_x = 1;
  int   cur_y = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] btn, input int k, input bit blk, input bit qry,
                              input int tx, input int ty, input int ex, input int ey,
                              input logic [1:0] fac, input int anim, input bit mov);
    vec_t v;
    v.btn = btn; v.k = k; v.blk = blk; v.qry = qry; v.tx = tx; v.ty = ty;
    v.ex = ex; v.ey = ey; v.fac = fac; v.anim = anim; v.mov = mov;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = v.btn;
    tick_in = ~tick_in;
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    chk($sformatf("v%0d qry_valid", idx), qry_valid, v.qry);
    chk($sformatf("v%0d facing", idx), facing, v.fac);
    if (v.qry) begin
      chk($sformatf("v%0d qry_x", idx), qry_x, v.tx);
      chk($sformatf("v%0d qry_y", idx), qry_y, v.ty);
      for (int j = 1; j < v.k; j++) begin
        @(negedge clk);
        chk($sformatf("v%0d qry_hold", idx), qry_valid, 1);
        chk($sformatf("v%0d qry_x_stable", idx), qry_x, v.tx);
        chk($sformatf("v%0d qry_y_stable", idx), qry_y, v.ty);
      end
      qry_ack = 1'b1;
      qry_blocked = v.blk;
      @(negedge clk);
      qry_ack = 1'b0;
      qry_blocked = 1'b0;
      chk($sformatf("v%0d qry_drop", idx), qry_valid, 0);
      chk($sformatf("v%0d pos_x_early", idx), pos_x, cur_x);
      chk($sformatf("v%0d step_done_early", idx), step_done, 0);
    end
    @(negedge clk);
    chk($sformatf("v%0d pos_x", idx), pos_x, v.ex);
    chk($sformatf("v%0d pos_y", idx), pos_y, v.ey);
    chk($sformatf("v%0d anim", idx), anim_frame, v.anim);
    chk($sformatf("v%0d moving", idx), moving, v.mov);
    chk($sformatf("v%0d step_done", idx), step_done, v.qry && !v.blk);
    @(negedge clk);
    chk($sformatf("v%0d step_done_clr", idx), step_done, 0);
    cur_x = v.ex;
    cur_y = v.ey;
  endtask

  initial begin
    int n;
    int hi;
    int rises;
    logic prev_v;

    n = 0;
    vecs[n++] = mk(4'b0001, 1, 0, 1, 2, 1, 2, 1, 2'b11, 1, 1);
    vecs[n++] = mk(4'b0001, 2, 0, 1, 3, 1, 3, 1, 2'b11, 2, 1);
    vecs[n++] = mk(4'b0001, 1, 0, 1, 4, 1, 4, 1, 2'b11, 3, 1);
    vecs[n++] = mk(4'b0001, 3, 0, 1, 5, 1, 5, 1, 2'b11, 0, 1);
    vecs[n++] = mk(4'b0001, 1, 0, 1, 6, 1, 6, 1, 2'b11, 1, 1);
    vecs[n++] = mk(4'b0000, 0, 0, 0, 0, 0, 6, 1, 2'b11, 0, 0);
    vecs[n++] = mk(4'b1000, 1, 0, 1, 6, 0, 6, 0, 2'b00, 1, 1);
    vecs[n++] = mk(4'b1000, 0, 0, 0, 0, 0, 6, 0, 2'b00, 0, 0);
    vecs[n++] = mk(4'b0010, 2, 1, 1, 5, 0, 6, 0, 2'b10, 0, 0);
    vecs[n++] = mk(4'b0100, 1, 0, 1, 6, 1, 6, 1, 2'b01, 1, 1);
    for (int i = 0; i < 6; i++)
      vecs[n++] = mk(4'b0010, 1, 0, 1, 5 - i, 1, 5 - i, 1, 2'b10, (i + 2) % 4, 1);
    vecs[n++] = mk(4'b0010, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0);
    for (int i = 0; i < 13; i++)
      vecs[n++] = mk(4'b0100, 1 + (i % 3), 0, 1, 0, 2 + i, 0, 2 + i, 2'b01, (i + 1) % 4, 1);
    vecs[n++] = mk(4'b0100, 0, 0, 0, 0, 0, 0, 14, 2'b01, 0, 0);
    vecs[n++] = mk(4'b1110, 1, 0, 1, 0, 13, 0, 13, 2'b00, 1, 1);
    vecs[n++] = mk(4'b0011, 0, 0, 0, 0, 0, 0, 13, 2'b10, 0, 0);
    vecs[n++] = mk(4'b1001, 5, 0, 1, 0, 12, 0, 12, 2'b00, 1, 1);
    vecs[n++] = mk(4'b0111, 1, 0, 1, 0, 13, 0, 13, 2'b01, 2, 1);

    rst = 1'b1;
    tick_in = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    qry_ack = 1'b0;
    qry_blocked = 1'b0;
    #1;
    chk("rst pos_x", pos_x, 1);
    chk("rst pos_y", pos_y, 1);
    chk("rst facing", facing, 2'b01);
    chk("rst anim", anim_frame, 0);
    chk("rst moving", moving, 0);
    chk("rst qry_valid", qry_valid, 0);
    chk("rst qry_x", qry_x, 0);
    chk("rst qry_y", qry_y, 0);
    chk("rst step_done", step_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < n; i++) run_vec(vecs[i], i);

    // Ack while no query is outstanding must change nothing.
    @(negedge clk);
    qry_ack = 1'b1;
    repeat (3) @(negedge clk);
    qry_ack = 1'b0;
    chk("ack_idle qry_valid", qry_valid, 0);
    chk("ack_idle pos_y", pos_y, 13);
    chk("ack_idle step_done", step_done, 0);
    chk("ack_idle moving", moving, 1);

    // Never acked; a second tick edge mid-query must be dropped.
    @(negedge clk);
    btn_right = 1'b1;
    tick_in = ~tick_in;
    @(negedge clk);
    hi = 0;
    for (int c = 0; c < 60 && qry_valid; c++) begin
      hi++;
      if (hi == 5) tick_in = ~tick_in;
      @(negedge clk);
    end
    chk("timeout len", hi, 15);
    rises = 0;
    prev_v = qry_valid;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (qry_valid && !prev_v) rises++;
      prev_v = qry_valid;
    end
    btn_right = 1'b0;
    chk("timeout requery", rises, 0);
    chk("timeout qry_valid", qry_valid, 0);
    chk("timeout pos_x", pos_x, 0);
    chk("timeout facing", facing, 2'b11);
    chk("timeout moving", moving, 0);
    chk("timeout anim", anim_frame, 0);

    // Reset in the middle of an outstanding query.
    @(negedge clk);
    btn_up = 1'b1;
    tick_in = ~tick_in;
    @(negedge clk);
    btn_up = 1'b0;
    chk("rstq qry_valid", qry_valid, 1);
    chk("rstq qry_y", qry_y, 12);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstq drop", qry_valid, 0);
    chk("rstq pos_x", pos_x, 1);
    chk("rstq pos_y", pos_y, 1);
    chk("rstq facing", facing, 2'b01);
    chk("rstq qry_y0", qry_y, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstq after qry_valid", qry_valid, 0);
    chk("rstq after pos_y", pos_y, 1);
    chk("rstq after step_done", step_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/player_step_ctrl.md
# player_step_ctrl

Consumes the slow game tick from the 250 ms clock divider and advances the player sprite one tile per tick on the map grid. It samples the direction buttons on each tick edge and asks the map ROM/collision unit whether the target tile is blocked through a valid/ack query. It then updates the tile position, facing and walk-animation frame that feed the VGA sprite renderer. The tick is treated as a data signal, never as a clock.

## Interface
Parameters:
- GRID_W, 20, map width in tiles
- GRID_H, 15, map height in tiles
- X_W, 5, width of x coordinates
- Y_W, 4, width of y coordinates
- START_X, 1, reset x tile
- START_Y, 1, reset y tile
- QRY_TIMEOUT, 15, cycles to wait for qry_ack before treating target as blocked

Ports:
- clk  in  1  system clock; the only clock in the block
- rst  in  1  asynchronous, active-high reset
- tick_in  in  1  divider square wave, synchronous to clk
- btn_up, btn_down, btn_left, btn_right  in  1 each  level direction buttons, already debounced
- qry_valid  out  1  collision query request
- qry_x  out  X_W  target tile x, stable while qry_valid=1
- qry_y  out  Y_W  target tile y, stable while qry_valid=1
- qry_ack  in  1  query answered; valid only while qry_valid=1
- qry_blocked  in  1  target tile is a wall; sampled with qry_ack
- pos_x  out  X_W  current tile x
- pos_y  out  Y_W  current tile y
- facing  out  2  00 up, 01 down, 10 left, 11 right
- anim_frame  out  2  walk-cycle frame
- moving  out  1  last tick produced a move
- step_done  out  1  one-cycle pulse after the position updates

## Operation
- Step event: tick_q is a register copy of tick_in, and step = tick_in ^ tick_q. Every tick_in transition, rising or falling, is one step.
- Direction priority at a step: up > down > left > right. The buttons are sampled only in the step cycle.
- FSM states: IDLE, QUERY, MOVE.
- IDLE + step + no button: moving<=0, anim_frame<=0. Stay in IDLE.
- IDLE + step + button:
  - facing<=dir; latch the direction.
  - Target = pos ±1 on the selected axis.
  - If the target is off-grid (x=0 going left, x=GRID_W-1 going right, y=0 going up, y=GRID_H-1 going down): moving<=0, anim_frame<=0, stay in IDLE, no query issued.
  - Otherwise: load qry_x/qry_y, qry_valid<=1, clear the timeout counter, go to QUERY.
- QUERY:
  - qry_valid held at 1 with constant coordinates.
  - On qry_ack with qry_blocked=1: qry_valid<=0, moving<=0, anim_frame<=0, go to IDLE.
  - On qry_ack with qry_blocked=0: qry_valid<=0, go to MOVE.
  - If the counter reaches QRY_TIMEOUT with no ack: handle as blocked.
- MOVE (one cycle):
  - pos<=target.
  - anim_frame<=anim_frame+1, wrapping 3->0.
  - moving<=1, step_done<=1 for the following cycle.
  - Go to IDLE.
- Steps that arrive in QUERY or MOVE are dropped, not queued.
- qry_ack while qry_valid=0 is ignored.
- Facing updates even when the move is blocked or off-grid.
- Coordinates are unsigned. The off-grid check prevents wrap-around, so pos always satisfies 0<=x<GRID_W and 0<=y<GRID_H.

## Timing
- Reset values (async, immediate):
  - pos_x=START_X, pos_y=START_Y
  - facing=01, anim_frame=0, moving=0
  - qry_valid=0, qry_x=0, qry_y=0, step_done=0
  - tick_q=0, state=IDLE
- If tick_in=1 at reset release, the first clk edge sees a step. This is intended, because the divider resets low.
- Step consumed at edge E (first edge where tick_in≠tick_q):
  - qry_valid and facing take their new values after E.
  - An ack sampled at edge E+k (k>=1) moves the FSM to MOVE after E+k.
  - pos, anim_frame and moving update at E+k+1.
  - step_done is high for exactly the cycle after E+k+1.
- Best-case tick-to-position latency is 2 edges, with the ack at E+1.
- Timeout: with no ack, qry_valid deasserts after edge E+QRY_TIMEOUT.
- Reset asserted during QUERY drops qry_valid immediately; no move is performed.

## Test plan
- Reset at START (1,1), btn_right held, tick_in toggles, ack at E+1 with blocked=0 -> pos_x=2 at E+2, facing=11, anim_frame=1, moving=1, step_done one cycle.
- Five right steps from x=1, all unblocked -> anim_frame goes 1,2,3,0,1; pos_x reaches 6.
- btn_up at y=0, step -> no qry_valid, facing=00, moving=0, pos unchanged.
- btn_left, ack with blocked=1 -> pos unchanged, facing=10, moving=0, anim_frame=0, no step_done.
- Never ack -> qry_valid high exactly QRY_TIMEOUT cycles then low; pos unchanged. A second tick edge during QUERY is ignored (only one query issued).
- btn_up and btn_right both pressed with ack delayed 5 cycles -> qry_x/qry_y equal (x, y-1) and stay stable all 5 cycles; assert rst mid-QUERY -> outputs return to reset values at once.
